// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core, one instruction in flight.
// Optional perf counters are built when CORE_SEQ_PERF_CNT_EN is defined.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    input  logic [31:0] alu_busC,
    input  logic        alu_take_jmp,
    input  logic [31:0] rs1_data,
    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    output logic [4:0]  rf_rd,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [31:0] ctrl_wdata,
    output logic        retire,
    output logic        fault,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] addr_q, addr_d;
    logic        take_q, take_d;
    logic [31:0] ldata_q, ldata_d;
    logic        fault_q, fault_d;

    logic [6:0]  opc;
    logic        is_load, is_store, is_branch, is_auipc, is_jal, is_jalr, legal;
    logic [31:0] imm, wb_npc, jalr_sum;

    assign opc       = ir_q[6:0];
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    assign legal     = (opc == OPC_LUI) || is_auipc || is_jal || is_jalr || is_branch ||
                       is_load || is_store || (opc == OPC_OPIMM) || (opc == OPC_OP);

    // OP carries a shamt-style field in funct7 for the ALU's add/sub and shift-right variants
    always_comb begin
        imm = 32'd0;
        case (opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: imm = {{20{ir_q[31]}}, ir_q[31:20]};
            OPC_STORE:  imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OPC_BRANCH: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {ir_q[31:12], 12'b0};
            OPC_JAL:    imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            OPC_OP: begin
                if (ir_q[14:12] == 3'b000)      imm = {25'b0, ir_q[31:25]};
                else if (ir_q[14:12] == 3'b101) imm = {20'b0, ir_q[31:25], 5'b0};
                else                            imm = 32'd0;
            end
            default: imm = 32'd0;
        endcase
    end

    assign jalr_sum = rs1_data + imm;

    always_comb begin
        wb_npc = pc_q + 32'd4;
        if (is_jal)                   wb_npc = pc_q + imm;
        else if (is_jalr)             wb_npc = {jalr_sum[31:1], 1'b0};
        else if (is_branch && take_q) wb_npc = pc_q + imm;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        take_d   = take_q;
        ldata_d  = ldata_q;
        fault_d  = fault_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_EXEC: begin
                addr_d = alu_busC;
                if (is_branch) take_d = alu_take_jmp;
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_d    = pc_q + 32'd4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        ldata_d = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = (ir_q[11:7] != 5'd0) && !is_branch;
                rf_wsel = is_load || is_auipc;
                // a misaligned target still commits rd but freezes pc at the faulting instruction
                if (wb_npc[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    pc_d    = wb_npc;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        if (rst) retire = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            addr_q  <= 32'd0;
            take_q  <= 1'b0;
            ldata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            take_q  <= take_d;
            ldata_q <= ldata_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign alu_opcode = opc;
    assign alu_funct3 = ir_q[14:12];
    assign alu_imm    = imm;
    assign alu_pc     = pc_q;
    assign rf_rs1     = ir_q[19:15];
    assign rf_rs2     = ir_q[24:20];
    assign rf_rd      = ir_q[11:7];
    assign ctrl_wdata = is_auipc ? (pc_q + imm) : ldata_q;
    assign fault      = fault_q;

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

    assign cyc_d = cyc_q + 32'd1;
    assign ret_d = retire ? ret_q + 32'd1 : ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`else
    assign cyc_cnt = 32'd0;
    assign ret_cnt = 32'd0;
`endif

endmodule
